// File: rtl/simd_pkg.sv
// Shared command format for the SIMD issuer and the command queue that feeds it.
package simd_pkg;

   localparam int CMD_W      = 16;
   localparam int PROC_COUNT = 4;
   localparam int PROC_W     = $clog2(PROC_COUNT);

   typedef struct packed {
      logic [PROC_W-1:0]         proc;
      logic [3:0]                opcode;
      logic [CMD_W-PROC_W-5:0]   arg;
   } cmd_t;

endpackage

// File: rtl/cmd_fifo_mem.sv
// Command storage array: one synchronous write port and one registered read port.
module cmd_fifo_mem
   import simd_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  cmd_t                     i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output cmd_t                     o_rd_data
);

   cmd_t mem_q [DEPTH];
   cmd_t rd_data_d;
   cmd_t rd_data_q;

   // Read data holds its last value between reads so the consumer sees a stable command.
   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_en) begin
         rd_data_d = mem_q[i_rd_addr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   // Array contents are not reset.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/cmd_queue.sv
// Command FIFO shared by the host loader and the issuer: the issuer pops commands for
// dispatch and pushes writeback commands; the issuer wins the single write port.
module cmd_queue
   import simd_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_host_push,
   input  cmd_t                     i_host_cmd,
   output logic                     o_host_ready,
   input  logic                     i_rd,
   input  logic                     i_wr,
   input  cmd_t                     i_wr_cmd,
   output cmd_t                     o_cmd,
   output logic                     o_ack,
   output logic                     o_empty,
   output logic                     o_almost_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW      = $clog2(DEPTH);
   localparam int COUNT_W = AW + 1;

   logic [COUNT_W-1:0] rd_ptr_d, rd_ptr_q;
   logic [COUNT_W-1:0] wr_ptr_d, wr_ptr_q;
   logic [COUNT_W-1:0] count_d, count_q;
   logic               ack_d, ack_q;
   logic               empty_d, empty_q;
   logic               almost_full_d, almost_full_q;

   logic               empty;
   logic               full;
   logic               issuer_acc;
   logic               do_pop;
   logic               issuer_push;
   logic               host_ready;
   logic               host_push;
   logic               push_any;
   cmd_t               wr_data;

   // A pop frees a slot in the same cycle, so rd+wr on a full queue still goes through.
   always_comb begin
      empty         = (rd_ptr_q == wr_ptr_q);
      full          = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
      issuer_acc    = (i_rd | i_wr) & (!i_rd | !empty) & (!i_wr | !full | i_rd);
      do_pop        = issuer_acc & i_rd;
      issuer_push   = issuer_acc & i_wr;
      host_ready    = !(full & !do_pop) & !issuer_push;
      host_push     = i_host_push & host_ready;
      push_any      = issuer_push | host_push;
      wr_data       = issuer_push ? i_wr_cmd : i_host_cmd;
      rd_ptr_d      = rd_ptr_q + COUNT_W'(do_pop);
      wr_ptr_d      = wr_ptr_q + COUNT_W'(push_any);
      count_d       = count_q + COUNT_W'(push_any) - COUNT_W'(do_pop);
      ack_d         = issuer_acc;
      empty_d       = (count_d == '0);
      almost_full_d = (count_d >= COUNT_W'(AF_THRESH));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         ack_q         <= 1'b0;
         empty_q       <= 1'b1;
         almost_full_q <= 1'b0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         ack_q         <= ack_d;
         empty_q       <= empty_d;
         almost_full_q <= almost_full_d;
      end
   end

   cmd_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (push_any),
      .i_wr_addr (wr_ptr_q[AW-1:0]),
      .i_wr_data (wr_data),
      .i_rd_en   (do_pop),
      .i_rd_addr (rd_ptr_q[AW-1:0]),
      .o_rd_data (o_cmd)
   );

   assign o_host_ready  = host_ready;
   assign o_ack         = ack_q;
   assign o_empty       = empty_q;
   assign o_almost_full = almost_full_q;
   assign o_count       = count_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Scoreboard bench for cmd_queue: stimulus predicts each ack's command, a monitor checks it.
module tb_cmd_queue;
   import simd_pkg::*;

   localparam int DEPTH     = 16;
   localparam int AF_THRESH = 12;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_host_push;
   cmd_t       i_host_cmd;
   logic       o_host_ready;
   logic       i_rd;
   logic       i_wr;
   cmd_t       i_wr_cmd;
   cmd_t       o_cmd;
   logic       o_ack;
   logic       o_empty;
   logic       o_almost_full;
   logic [4:0] o_count;

   int   checks = 0;
   int   errors = 0;
   cmd_t model_q[$];
   cmd_t exp_q[$];
   cmd_t last_cmd;
   cmd_t mon_exp;

   always #5 i_clk = ~i_clk;

   cmd_queue #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_host_push   (i_host_push),
      .i_host_cmd    (i_host_cmd),
      .o_host_ready  (o_host_ready),
      .i_rd          (i_rd),
      .i_wr          (i_wr),
      .i_wr_cmd      (i_wr_cmd),
      .o_cmd         (o_cmd),
      .o_ack         (o_ack),
      .o_empty       (o_empty),
      .o_almost_full (o_almost_full),
      .o_count       (o_count)
   );

   function automatic cmd_t mk(input int v);
      return cmd_t'(16'(v));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkState();
      checkOutput("count", 32'(o_count), 32'(model_q.size()));
      checkOutput("empty", 32'(o_empty), 32'(model_q.size() == 0));
      checkOutput("almost_full", 32'(o_almost_full), 32'(model_q.size() >= AF_THRESH));
   endtask

   // One clock of stimulus; the queue model decides acceptance and queues the ack's command.
   task automatic applyStimulus(input logic push, input cmd_t hcmd, input logic rd,
                                input logic wr, input cmd_t wcmd);
      bit   m_empty, m_full, acc, pop, ready;
      m_empty = (model_q.size() == 0);
      m_full  = (model_q.size() == DEPTH);
      acc     = (rd || wr) && (!rd || !m_empty) && (!wr || !m_full || rd);
      pop     = acc && rd;
      ready   = !(m_full && !pop) && !(wr && acc);
      i_host_push = push;
      i_host_cmd  = hcmd;
      i_rd        = rd;
      i_wr        = wr;
      i_wr_cmd    = wcmd;
      #1;
      checkOutput("host_ready", 32'(o_host_ready), 32'(ready));
      if (pop) last_cmd = model_q.pop_front();
      if (acc && wr) model_q.push_back(wcmd);
      if (push && ready) model_q.push_back(hcmd);
      if (acc) exp_q.push_back(last_cmd);
      @(posedge i_clk);
      #1;
      i_host_push = 1'b0;
      i_rd        = 1'b0;
      i_wr        = 1'b0;
      checkState();
   endtask

   task automatic hostPush(input int v);
      applyStimulus(1'b1, mk(v), 1'b0, 1'b0, '0);
   endtask

   task automatic popOne();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
   endtask

   // Reset may coincide with an issuer pop; reset wins and no ack follows.
   task automatic applyReset(input logic rd);
      i_rst = 1'b1;
      i_rd  = rd;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      i_rd  = 1'b0;
      model_q.delete();
      last_cmd = '0;
      checkState();
      checkOutput("reset_ack", 32'(o_ack), 32'd0);
      checkOutput("reset_cmd", 32'(o_cmd), 32'd0);
   endtask

   always @(negedge i_clk) begin
      if (o_ack === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_ack: got ack with cmd %0h, expected no ack", o_cmd);
         end else begin
            mon_exp = exp_q.pop_front();
            if (o_cmd !== mon_exp) begin
               errors++;
               $display("[TB] FAIL ack_cmd: got %0h, expected %0h", o_cmd, mon_exp);
            end
         end
      end
   end

   initial begin
      i_rst       = 1'b1;
      i_host_push = 1'b0;
      i_host_cmd  = '0;
      i_rd        = 1'b0;
      i_wr        = 1'b0;
      i_wr_cmd    = '0;
      last_cmd    = '0;
      @(posedge i_clk);
      #1;
      applyReset(1'b0);

      $display("[TB] basic push/pop");
      hostPush(16'h0A01);
      hostPush(16'h0B02);
      hostPush(16'h0C03);
      repeat (3) popOne();
      checkOutput("t1_last_cmd", 32'(o_cmd), 32'h0C03);
      checkOutput("t1_empty", 32'(o_empty), 32'd1);

      $display("[TB] pop held on empty queue");
      repeat (3) popOne();
      applyStimulus(1'b1, mk(16'h0D04), 1'b1, 1'b0, '0);
      popOne();
      checkOutput("t2_cmd", 32'(o_cmd), 32'h0D04);

      $display("[TB] fill and swap on full");
      for (int i = 0; i < DEPTH; i++) hostPush(16'h3000 + i);
      checkOutput("t3_full_count", 32'(o_count), 32'd16);
      hostPush(16'h3FFF);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, mk(16'h3ABC));
      checkOutput("t3_swap_cmd", 32'(o_cmd), 32'h3000);
      repeat (DEPTH) popOne();
      checkOutput("t3_last_out", 32'(o_cmd), 32'h3ABC);

      $display("[TB] writeback beats host push");
      for (int i = 0; i < 5; i++) hostPush(16'h4000 + i);
      applyStimulus(1'b1, mk(16'h4BBB), 1'b0, 1'b1, mk(16'h4AAA));
      applyStimulus(1'b1, mk(16'h4BBB), 1'b0, 1'b0, '0);
      repeat (6) popOne();
      checkOutput("t4_writeback_cmd", 32'(o_cmd), 32'h4AAA);
      popOne();
      checkOutput("t4_host_cmd", 32'(o_cmd), 32'h4BBB);

      $display("[TB] pointer wrap");
      hostPush(0);
      for (int i = 1; i < 40; i++) applyStimulus(1'b1, mk(i), 1'b1, 1'b0, '0);
      popOne();
      checkOutput("t5_last_cmd", 32'(o_cmd), 32'd39);

      $display("[TB] reset mid-operation");
      for (int i = 0; i < 7; i++) hostPush(16'h6000 + i);
      applyReset(1'b1);
      popOne();
      checkOutput("t6_cmd_after_reset", 32'(o_cmd), 32'd0);

      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
